instr_mem_pipe: RTL and testbench

- Parametrised instruction memory with a valid/ready request/response handshake.
- Sits between Fetch (PC) and Decode.
- Adds to the basic fixed-width, 1-cycle, always-accepting memory:
  - programmable wait-state latency
  - response back-pressure from Decode
  - pipeline flush on redirect
  - misaligned and out-of-range error reporting
- Byte-addressed, big-endian: the byte at the lowest address is bits [WORD_W-1:WORD_W-8].

---
 rtl/instr_mem_pipe_pkg.sv | 23 ++
 rtl/instr_mem_array.sv | 38 +++
 rtl/instr_mem_pipe.sv | 135 +++++++++++++
 tb/tb_instr_mem_pipe.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pipe_pkg.sv
// Shared types for the instruction memory pipeline: FSM states, latency limit
// and the response holding-register layout.
package instr_mem_pipe_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } imem_state_t;

    localparam int unsigned IMEM_MAX_LATENCY = 8;

    // Field widths of the captured response; the top resizes into/out of these.
    localparam int unsigned IMEM_WORD_W = 32;
    localparam int unsigned IMEM_ADDR_W = 32;

    typedef struct packed {
        logic [IMEM_WORD_W-1:0] data;
        logic                   err;
        logic [IMEM_ADDR_W-1:0] addr;
    } imem_resp_t;

endpackage

// File: rtl/instr_mem_array.sv
// Byte-organised instruction storage with a combinational big-endian word read
// and, under INSTR_MEM_LOAD_PORT_EN, a synchronous big-endian word write.
module instr_mem_array #(
    parameter  int unsigned MEM_BYTES  = 1024,
    parameter  int unsigned WORD_BYTES = 4,
    localparam int unsigned IDX_W      = $clog2(MEM_BYTES),
    localparam int unsigned WORD_W     = 8 * WORD_BYTES
) (
`ifdef INSTR_MEM_LOAD_PORT_EN
    input  logic              clock,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [WORD_W-1:0] wr_data,
`endif
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [WORD_W-1:0] rd_word
);

    logic [7:0] mem [MEM_BYTES] = '{default: '0};

    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            rd_word[WORD_W-1-8*i -: 8] = mem[rd_addr + IDX_W'(i)];
        end
    end

`ifdef INSTR_MEM_LOAD_PORT_EN
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < WORD_BYTES; i++) begin
                mem[wr_addr + IDX_W'(i)] <= wr_data[WORD_W-1-8*i -: 8];
            end
        end
    end
`endif

endmodule

// File: rtl/instr_mem_pipe.sv
// Instruction memory with valid/ready handshake, programmable wait states,
// flush and error reporting. Optional load port: INSTR_MEM_LOAD_PORT_EN.
module instr_mem_pipe
    import instr_mem_pipe_pkg::*;
#(
    parameter int unsigned MEM_BYTES  = 1024,
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LATENCY    = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    mem_en,
    input  logic                    flush,
    input  logic                    req_valid,
    input  logic [ADDR_W-1:0]       req_addr,
    output logic                    req_ready,
    output logic                    resp_valid,
    output logic [8*WORD_BYTES-1:0] resp_data,
    output logic                    resp_err,
    output logic [ADDR_W-1:0]       resp_addr,
`ifdef INSTR_MEM_LOAD_PORT_EN
    input  logic                    ld_en,
    input  logic [ADDR_W-1:0]       ld_addr,
    input  logic [8*WORD_BYTES-1:0] ld_data,
`endif
    input  logic                    resp_ready
);

    localparam int unsigned WORD_W = 8 * WORD_BYTES;
    localparam int unsigned IDX_W  = $clog2(MEM_BYTES);
    localparam int unsigned CNT_W  = $clog2(IMEM_MAX_LATENCY);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MEM_BYTES - WORD_BYTES);
    localparam logic [ADDR_W-1:0] WORD_BYTES_A = ADDR_W'(WORD_BYTES);
    localparam imem_state_t ISSUE_STATE = (LATENCY == 1) ? RESP : WAIT;

    imem_state_t       state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    imem_resp_t        hold;
    logic              accept;
    logic              req_err;
    logic [IDX_W-1:0]  rd_idx;
    logic [WORD_W-1:0] rd_word;

    assign req_ready = mem_en & ~flush & ((state == IDLE) | ((state == RESP) & resp_ready));
    assign accept    = req_valid & req_ready;

    // Range test on the full address so an out-of-range index never wraps.
    assign req_err = ((req_addr % WORD_BYTES_A) != '0) | (req_addr > LAST_ADDR);
    assign rd_idx  = req_err ? '0 : req_addr[IDX_W-1:0];

`ifdef INSTR_MEM_LOAD_PORT_EN
    logic ld_ok;

    assign ld_ok = ld_en & ((ld_addr % WORD_BYTES_A) == '0) & (ld_addr <= LAST_ADDR);

    instr_mem_array #(
        .MEM_BYTES (MEM_BYTES),
        .WORD_BYTES(WORD_BYTES)
    ) u_array (
        .clock  (clock),
        .wr_en  (ld_ok),
        .wr_addr(ld_addr[IDX_W-1:0]),
        .wr_data(ld_data),
        .rd_addr(rd_idx),
        .rd_word(rd_word)
    );
`else
    instr_mem_array #(
        .MEM_BYTES (MEM_BYTES),
        .WORD_BYTES(WORD_BYTES)
    ) u_array (
        .rd_addr(rd_idx),
        .rd_word(rd_word)
    );
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // WAIT leaves when the counter would reach zero, so the response becomes
    // visible exactly LATENCY cycles after the accept cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ISSUE_STATE;
                    cnt_next   = CNT_W'(LATENCY - 1);
                end
            end
            WAIT: begin
                cnt_next = cnt - 1'b1;
                if (cnt == CNT_W'(1)) state_next = RESP;
            end
            RESP: begin
                if (accept) begin
                    state_next = ISSUE_STATE;
                    cnt_next   = CNT_W'(LATENCY - 1);
                end else if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
            cnt_next   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hold <= '0;
        end else if (accept) begin
            hold.data <= req_err ? '0 : IMEM_WORD_W'(rd_word);
            hold.err  <= req_err;
            hold.addr <= IMEM_ADDR_W'(req_addr);
        end
    end

    assign resp_valid = (state == RESP);
    assign resp_data  = WORD_W'(hold.data);
    assign resp_err   = hold.err;
    assign resp_addr  = ADDR_W'(hold.addr);

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Scoreboard bench for instr_mem_pipe: dut0 with LATENCY=1, dut1 with LATENCY=3.
module tb_instr_mem_pipe;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        err;
        logic [31:0] addr;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_en     [2];
    logic        flush      [2];
    logic        req_valid  [2];
    logic [31:0] req_addr   [2];
    logic        req_ready  [2];
    logic        resp_valid [2];
    logic [31:0] resp_data  [2];
    logic        resp_err   [2];
    logic [31:0] resp_addr  [2];
    logic        resp_ready [2];
`ifdef INSTR_MEM_LOAD_PORT_EN
    logic        ld_en      [2];
    logic [31:0] ld_addr    [2];
    logic [31:0] ld_data    [2];
`endif

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_mem_pipe #(.MEM_BYTES(1024), .WORD_BYTES(4), .ADDR_W(32), .LATENCY(1)) dut0 (
        .clock(clk), .reset(reset), .mem_en(mem_en[0]), .flush(flush[0]),
        .req_valid(req_valid[0]), .req_addr(req_addr[0]), .req_ready(req_ready[0]),
        .resp_valid(resp_valid[0]), .resp_data(resp_data[0]), .resp_err(resp_err[0]),
        .resp_addr(resp_addr[0]),
`ifdef INSTR_MEM_LOAD_PORT_EN
        .ld_en(ld_en[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0]),
`endif
        .resp_ready(resp_ready[0])
    );

    instr_mem_pipe #(.MEM_BYTES(1024), .WORD_BYTES(4), .ADDR_W(32), .LATENCY(3)) dut1 (
        .clock(clk), .reset(reset), .mem_en(mem_en[1]), .flush(flush[1]),
        .req_valid(req_valid[1]), .req_addr(req_addr[1]), .req_ready(req_ready[1]),
        .resp_valid(resp_valid[1]), .resp_data(resp_data[1]), .resp_err(resp_err[1]),
        .resp_addr(resp_addr[1]),
`ifdef INSTR_MEM_LOAD_PORT_EN
        .ld_en(ld_en[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1]),
`endif
        .resp_ready(resp_ready[1])
    );

    task automatic check(input int id, input string name, input logic [95:0] act,
                         input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %0h expected %0h (cycle %0d)", id, name, act, exp, cyc);
        end
    endtask

    function automatic int find_first(input int id);
        for (int k = 0; k < q.size(); k++) if (q[k].id == id) return k;
        return -1;
    endfunction

    function automatic void drop_last(input int id);
        for (int k = q.size() - 1; k >= 0; k--) begin
            if (q[k].id == id) begin
                q.delete(k);
                return;
            end
        end
    endfunction

    // Drive a request; returns after the accept edge, having queued the expectation.
    task automatic issue(input int id, input logic [31:0] addr, input logic [31:0] data,
                         input logic err, output int waited);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        waited = 0;
        req_valid[id] = 1'b1;
        req_addr[id]  = addr;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
            waited++;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut%0d accept_timeout: got no req_ready expected accept of %0h", id, addr);
            req_valid[id] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e.id   = id;
        e.data = data;
        e.err  = err;
        e.addr = addr;
        e.due  = cyc + ((id == 0) ? 1 : 3) - 1;
        q.push_back(e);
        req_valid[id] = 1'b0;
    endtask

    // Monitor: pops on each handshake, checks hold stability and first-visible cycle.
    bit          fresh [2] = '{1'b1, 1'b1};
    int          first [2];
    logic [64:0] snap  [2];

    always @(negedge clk) begin
        if (reset) begin
            fresh[0] = 1'b1;
            fresh[1] = 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (resp_valid[i]) begin
                    if (fresh[i]) begin
                        first[i] = cyc;
                        snap[i]  = {resp_data[i], resp_err[i], resp_addr[i]};
                        fresh[i] = 1'b0;
                    end else begin
                        check(i, "held_outputs_stable",
                              {resp_data[i], resp_err[i], resp_addr[i]}, snap[i]);
                    end
                    if (resp_ready[i]) begin
                        int   idx;
                        exp_t e;
                        idx = find_first(i);
                        if (idx < 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL dut%0d unexpected_response: got addr %0h expected none",
                                     i, resp_addr[i]);
                        end else begin
                            e = q[idx];
                            q.delete(idx);
                            check(i, "resp_data", resp_data[i], e.data);
                            check(i, "resp_err", resp_err[i], e.err);
                            check(i, "resp_addr", resp_addr[i], e.addr);
                            check(i, "resp_first_cycle", first[i], e.due);
                        end
                        fresh[i] = 1'b1;
                    end else begin
                        check(i, "req_ready_while_held", req_ready[i], 1'b0);
                    end
                end else begin
                    fresh[i] = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        logic [31:0] word;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mem_en[i] = 1'b1;  flush[i] = 1'b0;     req_valid[i] = 1'b0;
            req_addr[i] = '0;  resp_ready[i] = 1'b0;
`ifdef INSTR_MEM_LOAD_PORT_EN
            ld_en[i] = 1'b0;   ld_addr[i] = '0;     ld_data[i] = '0;
`endif
        end
        #1;
        // Word at byte address a is C0DE_0000|a, except bytes 0..3 = 01 23 45 67.
        for (int a = 0; a < 1024; a += 4) begin
            word = (a == 0) ? 32'h0123_4567 : (32'hC0DE_0000 | a);
            for (int j = 0; j < 4; j++) begin
                dut0.u_array.mem[a + j] = word[31 - 8*j -: 8];
                dut1.u_array.mem[a + j] = word[31 - 8*j -: 8];
            end
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check(i, "reset_resp_valid", resp_valid[i], 1'b0);
            check(i, "reset_resp_data", resp_data[i], 32'h0);
            check(i, "reset_resp_err", resp_err[i], 1'b0);
            check(i, "reset_resp_addr", resp_addr[i], 32'h0);
            check(i, "reset_req_ready", req_ready[i], 1'b1);
        end
        @(posedge clk); #1;

        // LATENCY=1 basic read, then error boundaries back to back.
        resp_ready[0] = 1'b1;
        issue(0, 32'h0, 32'h0123_4567, 1'b0, w);
        issue(0, 32'h2, 32'h0, 1'b1, w);
        check(0, "l1_back_to_back_wait", w, 0);
        issue(0, 32'h400, 32'h0, 1'b1, w);
        issue(0, 32'h3FC, 32'hC0DE_03FC, 1'b0, w);
        check(0, "l1_back_to_back_wait", w, 0);
        repeat (3) @(posedge clk); #1;

        // mem_en low blocks accepts.
        mem_en[0] = 1'b0; req_valid[0] = 1'b1; req_addr[0] = 32'h8;
        @(negedge clk); check(0, "mem_en_low_req_ready", req_ready[0], 1'b0);
        @(negedge clk); check(0, "mem_en_low_req_ready", req_ready[0], 1'b0);
        @(posedge clk); #1;
        req_valid[0] = 1'b0; mem_en[0] = 1'b1;
        repeat (3) @(posedge clk); #1;

`ifdef INSTR_MEM_LOAD_PORT_EN
        // Load in the same cycle as the read returns the old word.
        ld_en[0] = 1'b1; ld_addr[0] = 32'h10; ld_data[0] = 32'hDEAD_BEEF;
        issue(0, 32'h10, 32'hC0DE_0010, 1'b0, w);
        ld_en[0] = 1'b0;
        issue(0, 32'h10, 32'hDEAD_BEEF, 1'b0, w);
        repeat (3) @(posedge clk); #1;
`endif

        // LATENCY=3 streaming; req_ready must stay low for the two WAIT cycles.
        resp_ready[1] = 1'b1;
        issue(1, 32'h0, 32'h0123_4567, 1'b0, w);
        issue(1, 32'h4, 32'hC0DE_0004, 1'b0, w);
        check(1, "l3_wait_cycles_not_ready", w, 2);
        issue(1, 32'h8, 32'hC0DE_0008, 1'b0, w);
        check(1, "l3_wait_cycles_not_ready", w, 2);
        repeat (6) @(posedge clk); #1;

        // Back-pressure: hold 0x4 for 5 cycles, then consume and accept 0x8 together.
        resp_ready[1] = 1'b0;
        issue(1, 32'h4, 32'hC0DE_0004, 1'b0, w);
        for (int n = 0; n < 20 && !resp_valid[1]; n++) @(negedge clk);
        check(1, "hold_resp_valid_seen", resp_valid[1], 1'b1);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        resp_ready[1] = 1'b1;
        issue(1, 32'h8, 32'hC0DE_0008, 1'b0, w);
        check(1, "no_bubble_accept_wait", w, 0);
        repeat (6) @(posedge clk); #1;

        // Flush during WAIT kills the response and blocks the same-cycle request.
        issue(1, 32'hC, 32'hC0DE_000C, 1'b0, w);
        flush[1] = 1'b1; req_valid[1] = 1'b1; req_addr[1] = 32'h10;
        drop_last(1);
        @(negedge clk); check(1, "flush_req_ready", req_ready[1], 1'b0);
        @(posedge clk); #1;
        flush[1] = 1'b0; req_valid[1] = 1'b0;
        repeat (6) @(negedge clk);
        check(1, "flush_no_response", resp_valid[1], 1'b0);
        @(posedge clk); #1;

        // Reset mid-flight drops the request and clears outputs.
        issue(1, 32'h14, 32'hC0DE_0014, 1'b0, w);
        reset = 1'b1;
        drop_last(1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check(1, "midreset_resp_valid", resp_valid[1], 1'b0);
        check(1, "midreset_resp_data", resp_data[1], 32'h0);
        check(1, "midreset_resp_addr", resp_addr[1], 32'h0);
        repeat (6) @(negedge clk);
        check(1, "midreset_no_response", resp_valid[1], 1'b0);

        for (int n = 0; n < 100 && q.size() != 0; n++) @(negedge clk);
        check(0, "scoreboard_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
